// File: rtl/ce_gen_pkg.sv
// ce_gen_pkg
//   Shared definitions for the clock-enable pulse generator.
//   - state_t   : FSM encoding (IDLE / RUN)
//   - DEF_DIV_DFLT, DEF_PM1_DFLT : default reset period and its period-minus-one
//   - period_m1 : maps a period d to (d-1) mod 2**w, so d=0 means 2**w
package ce_gen_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_DIV_DFLT = 8;
  localparam int DEF_PM1_DFLT = DEF_DIV_DFLT - 1;

  // Elaboration-time helper; d=0 wraps to the all-ones value (period 2**w).
  function automatic int period_m1(input int d, input int w);
    return (d + (1 << w) - 1) % (1 << w);
  endfunction

endpackage

// File: rtl/ce_pulse_gen.sv
// ce_pulse_gen
//   Programmable clock-enable generator. A loadable counter emits a one-cycle
//   CEO strobe every DIV enabled clocks; runs continuously or one-shot and
//   cascades through ce -> CEO.
//
//   Optional build macro: CE_PULSE_GEN_UPDOWN_EN adds the `up` input. With
//   up=1 the counter runs 0..pm1 and terminates at Q==pm1; with up=0 (or the
//   macro undefined) it runs pm1..0 and terminates at Q==0.
//
// Ports
//   clk      in   system clock, rising edge
//   clr      in   synchronous active-high reset, highest priority
//   ce       in   count enable / cascade input
//   load     in   latch div into the period register
//   div      in   period in enabled cycles, 0 = 2**WIDTH
//   start    in   begin or restart a count
//   oneshot  in   sampled at terminal count: 1 = stop, 0 = reload
//   up       in   count direction (only with CE_PULSE_GEN_UPDOWN_EN)
//   Q        out  current count
//   TC       out  terminal count, decoded from registers only
//   CEO      out  TC & ce, the only combinational path
//   busy     out  high while running
module ce_pulse_gen
  import ce_gen_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int DEF_DIV = DEF_DIV_DFLT
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ce,
  input  logic             load,
  input  logic [WIDTH-1:0] div,
  input  logic             start,
  input  logic             oneshot,
`ifdef CE_PULSE_GEN_UPDOWN_EN
  input  logic             up,
`endif
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             CEO,
  output logic             busy
);

  localparam logic [WIDTH-1:0] RST_PM1 = WIDTH'(period_m1(DEF_DIV, WIDTH));

  state_t           state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] pm1;
  logic             up_eff;
  logic [WIDTH-1:0] pm1_nxt;
  logic [WIDTH-1:0] start_val;
  logic [WIDTH-1:0] step_val;
  logic             term;

`ifdef CE_PULSE_GEN_UPDOWN_EN
  assign up_eff = up;
`else
  assign up_eff = 1'b0;
`endif

  // A load in the same cycle as start/reload takes effect immediately.
  always_comb begin
    pm1_nxt   = load ? (div - WIDTH'(1)) : pm1;
    start_val = up_eff ? '0 : pm1_nxt;
    step_val  = up_eff ? (cnt + WIDTH'(1)) : (cnt - WIDTH'(1));
    term      = up_eff ? (cnt == pm1) : (cnt == '0);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      cnt   <= '0;
      pm1   <= RST_PM1;
    end else begin
      if (load) pm1 <= pm1_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            cnt   <= start_val;
          end
        end
        RUN: begin
          // start overrides both the decrement and the terminal action
          if (start) begin
            cnt <= start_val;
          end else if (ce) begin
            if (term) begin
              if (oneshot) state <= IDLE;
              else         cnt   <= start_val;
            end else begin
              cnt <= step_val;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Q    = cnt;
  assign busy = (state == RUN);
  assign TC   = busy & term;
  assign CEO  = TC & ce;

endmodule

// File: tb/tb_ce_pulse_gen.sv
// tb_ce_pulse_gen
//   Scoreboard bench for ce_pulse_gen (WIDTH=4, DEF_DIV=8). Each test task
//   pushes the expected observation for a cycle, runs the cycle, then pops
//   and compares. An observation is CEO sampled before the edge (with the
//   cycle's inputs applied) plus Q/TC/busy sampled just after the edge.
//   Define CE_PULSE_GEN_UPDOWN_EN to also connect `up` and run the up-count test.
module tb_ce_pulse_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clr, ce, load, start, oneshot;
  logic [3:0] div;
`ifdef CE_PULSE_GEN_UPDOWN_EN
  logic       up;
`endif
  logic [3:0] Q;
  logic       TC, CEO, busy;

  ce_pulse_gen #(.WIDTH(4), .DEF_DIV(8)) dut (
    .clk(clk), .clr(clr), .ce(ce), .load(load), .div(div),
    .start(start), .oneshot(oneshot),
`ifdef CE_PULSE_GEN_UPDOWN_EN
    .up(up),
`endif
    .Q(Q), .TC(TC), .CEO(CEO), .busy(busy)
  );

  typedef struct packed {
    logic [3:0] q;
    logic       tc;
    logic       busy;
    logic       ceo;
  } obs_t;

  obs_t exp_q[$];
  obs_t obs, e;
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic string fmt(input obs_t o);
    return $sformatf("q=%0d tc=%b busy=%b ceo=%b", o.q, o.tc, o.busy, o.ceo);
  endfunction

  function automatic obs_t mk(input int q, input bit tc, input bit bz, input bit ceo);
    obs_t o;
    o.q = 4'(q); o.tc = tc; o.busy = bz; o.ceo = ceo;
    return o;
  endfunction

  // Called at posedge+1 with inputs already set; returns at the next posedge+1.
  task automatic cycle();
    #1 obs.ceo = CEO;
    @(posedge clk);
    #1;
    obs.q    = Q;
    obs.tc   = TC;
    obs.busy = busy;
  endtask

  task automatic strobes_off();
    clr = 1'b0; load = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b1; ce = 1'b1; load = 1'b1; div = 4'd3; start = 1'b1; oneshot = 1'b0;
    exp_q.push_back(mk(0, 0, 0, 0));
    cycle();
    e = exp_q.pop_front();
    n_cmp++;
    if ({obs.q, obs.tc, obs.busy} !== {e.q, e.tc, e.busy}) begin
      n_bad++;
      $display("FAIL reset_state: got %s, want %s (ceo ignored)", fmt(obs), fmt(e));
    end
    strobes_off();
    exp_q.push_back(mk(0, 0, 0, 0));
    cycle();
    e = exp_q.pop_front();
    n_cmp++;
    if (obs !== e) begin
      n_bad++;
      $display("FAIL reset_idle: got %s, want %s", fmt(obs), fmt(e));
    end
  endtask

  task automatic test_continuous();
    int pre, post, n_ceo;
    n_ceo = 0;
    start = 1'b1; ce = 1'b1; oneshot = 1'b0;
    exp_q.push_back(mk(7, 0, 1, 0));
    cycle();
    start = 1'b0;
    e = exp_q.pop_front();
    n_cmp++;
    if (obs !== e) begin
      n_bad++;
      $display("FAIL cont_start: got %s, want %s", fmt(obs), fmt(e));
    end
    for (int i = 0; i < 24; i++) begin
      pre  = 7 - (i % 8);
      post = 7 - ((i + 1) % 8);
      exp_q.push_back(mk(post, post == 0, 1, pre == 0));
      cycle();
      if (obs.ceo === 1'b1) n_ceo++;
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL cont[%0d]: got %s, want %s", i, fmt(obs), fmt(e));
      end
    end
    n_cmp++;
    if (n_ceo !== 3) begin
      n_bad++;
      $display("FAIL cont_ceo_count: got %0d, want 3", n_ceo);
    end
  endtask

  task automatic test_ce_gating();
    int q, n_ceo;
    bit pre_ceo;
    n_ceo = 0;
    // load alone mid-RUN must not disturb Q (7 here)
    load = 1'b1; div = 4'd3; ce = 1'b0;
    exp_q.push_back(mk(7, 0, 1, 0));
    cycle();
    load = 1'b0;
    e = exp_q.pop_front();
    n_cmp++;
    if (obs !== e) begin
      n_bad++;
      $display("FAIL gate_load: got %s, want %s", fmt(obs), fmt(e));
    end
    start = 1'b1;
    exp_q.push_back(mk(2, 0, 1, 0));
    cycle();
    start = 1'b0;
    e = exp_q.pop_front();
    n_cmp++;
    if (obs !== e) begin
      n_bad++;
      $display("FAIL gate_restart: got %s, want %s", fmt(obs), fmt(e));
    end
    q = 2;
    for (int i = 0; i < 24; i++) begin
      ce = (i % 4 == 3);
      pre_ceo = ce && (q == 0);
      if (ce) q = (q == 0) ? 2 : q - 1;
      exp_q.push_back(mk(q, q == 0, 1, pre_ceo));
      cycle();
      if (obs.ceo === 1'b1) n_ceo++;
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL gate[%0d]: got %s, want %s", i, fmt(obs), fmt(e));
      end
    end
    n_cmp++;
    if (n_ceo !== 2) begin
      n_bad++;
      $display("FAIL gate_ceo_count: got %0d, want 2", n_ceo);
    end
  endtask

  task automatic test_oneshot();
    obs_t seq[6];
    ce = 1'b0; clr = 1'b1;
    exp_q.push_back(mk(0, 0, 0, 0));
    cycle();
    clr = 1'b0;
    e = exp_q.pop_front();
    n_cmp++;
    if (obs !== e) begin
      n_bad++;
      $display("FAIL os_clr: got %s, want %s", fmt(obs), fmt(e));
    end
    seq[0] = mk(1, 0, 1, 0);
    seq[1] = mk(0, 1, 1, 0);
    seq[2] = mk(0, 0, 0, 1);
    seq[3] = mk(0, 0, 0, 0);
    seq[4] = mk(0, 0, 0, 0);
    seq[5] = mk(0, 0, 0, 0);
    load = 1'b1; div = 4'd2; start = 1'b1; oneshot = 1'b1; ce = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(seq[i]);
      cycle();
      load = 1'b0; start = 1'b0;
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL oneshot[%0d]: got %s, want %s", i, fmt(obs), fmt(e));
      end
    end
    oneshot = 1'b0;
  endtask

  task automatic test_load();
    int q, pm1, last, n_ceo;
    bit pre_ceo;
    n_ceo = 0; last = -1;
    load = 1'b1; div = 4'd0; start = 1'b1; ce = 1'b1; oneshot = 1'b0;
    exp_q.push_back(mk(15, 0, 1, 0));
    cycle();
    strobes_off();
    e = exp_q.pop_front();
    n_cmp++;
    if (obs !== e) begin
      n_bad++;
      $display("FAIL load_div0: got %s, want %s", fmt(obs), fmt(e));
    end
    q = 15; pm1 = 15;
    for (int i = 0; i < 30; i++) begin
      load = (i == 5);
      div  = 4'd5;
      pre_ceo = (q == 0);
      if (i == 5) pm1 = 4;
      q = (q == 0) ? pm1 : q - 1;
      exp_q.push_back(mk(q, q == 0, 1, pre_ceo));
      cycle();
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL load[%0d]: got %s, want %s", i, fmt(obs), fmt(e));
      end
      if (obs.ceo === 1'b1) begin
        n_ceo++;
        if (last >= 0) begin
          n_cmp++;
          if (i - last !== 5) begin
            n_bad++;
            $display("FAIL load_period: got %0d, want 5", i - last);
          end
        end
        last = i;
      end
    end
    load = 1'b0;
    n_cmp++;
    if (n_ceo !== 3) begin
      n_bad++;
      $display("FAIL load_ceo_count: got %0d, want 3", n_ceo);
    end
  endtask

  task automatic test_clr_mid_run();
    obs_t seq[5];
    // RUN at Q=0, pm1=4 on entry
    seq[0] = mk(4, 0, 1, 1);   // restart while at TC: CEO still TC&ce
    seq[1] = mk(3, 0, 1, 0);
    seq[2] = mk(0, 0, 0, 0);   // clr with start/load: both discarded
    seq[3] = mk(0, 0, 0, 0);
    seq[4] = mk(7, 0, 1, 0);   // period register back to DEF_DIV-1
    for (int i = 0; i < 5; i++) begin
      strobes_off();
      ce = 1'b1;
      case (i)
        0: start = 1'b1;
        2: begin clr = 1'b1; start = 1'b1; load = 1'b1; div = 4'd2; end
        4: begin start = 1'b1; ce = 1'b0; end
        default: ;
      endcase
      exp_q.push_back(seq[i]);
      cycle();
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL clr[%0d]: got %s, want %s", i, fmt(obs), fmt(e));
      end
    end
    strobes_off();
  endtask

`ifdef CE_PULSE_GEN_UPDOWN_EN
  task automatic test_updown();
    int pre, post;
    ce = 1'b0; clr = 1'b1;
    exp_q.push_back(mk(0, 0, 0, 0));
    cycle();
    clr = 1'b0;
    e = exp_q.pop_front();
    n_cmp++;
    if (obs !== e) begin
      n_bad++;
      $display("FAIL ud_clr: got %s, want %s", fmt(obs), fmt(e));
    end
    up = 1'b1; load = 1'b1; div = 4'd4; start = 1'b1; ce = 1'b1; oneshot = 1'b0;
    exp_q.push_back(mk(0, 0, 1, 0));
    cycle();
    strobes_off();
    e = exp_q.pop_front();
    n_cmp++;
    if (obs !== e) begin
      n_bad++;
      $display("FAIL ud_start: got %s, want %s", fmt(obs), fmt(e));
    end
    for (int i = 0; i < 12; i++) begin
      pre  = i % 4;
      post = (i + 1) % 4;
      exp_q.push_back(mk(post, post == 3, 1, pre == 3));
      cycle();
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL ud[%0d]: got %s, want %s", i, fmt(obs), fmt(e));
      end
    end
    // switch to down at Q=0: terminal in down direction, reload to pm1
    up = 1'b0;
    exp_q.push_back(mk(3, 0, 1, 1));
    cycle();
    e = exp_q.pop_front();
    n_cmp++;
    if (obs !== e) begin
      n_bad++;
      $display("FAIL ud_dir_change: got %s, want %s", fmt(obs), fmt(e));
    end
  endtask
`endif

  initial begin
    clr = 1'b1; ce = 1'b0; load = 1'b0; div = '0; start = 1'b0; oneshot = 1'b0;
`ifdef CE_PULSE_GEN_UPDOWN_EN
    up = 1'b0;
`endif
    @(posedge clk);
    #1;
    test_reset();
    test_continuous();
    test_ce_gating();
    test_oneshot();
    test_load();
    test_clr_mid_run();
`ifdef CE_PULSE_GEN_UPDOWN_EN
    test_updown();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
